// File: rtl/nes_joypad_pkg.sv
// Shared constants and the SNES-to-NES button remap for the $4016/$4017 joypad port.
package nes_joypad_pkg;

  localparam int unsigned SNES_B      = 0;
  localparam int unsigned SNES_Y      = 1;
  localparam int unsigned SNES_SELECT = 2;
  localparam int unsigned SNES_START  = 3;
  localparam int unsigned SNES_UP     = 4;
  localparam int unsigned SNES_DOWN   = 5;
  localparam int unsigned SNES_LEFT   = 6;
  localparam int unsigned SNES_RIGHT  = 7;
  localparam int unsigned SNES_A      = 8;
  localparam int unsigned SNES_X      = 9;
  localparam int unsigned SNES_L      = 10;
  localparam int unsigned SNES_R      = 11;

  localparam logic [15:0] ADDR_JOY1 = 16'h4016;
  localparam logic [15:0] ADDR_JOY2 = 16'h4017;

  localparam logic [7:0] OPEN_BUS_DEFAULT = 8'h40;

  // NES serial order, bit0 shifted out first: {Right,Left,Down,Up,Start,Select,B,A}
  function automatic logic [7:0] snes_to_nes(input logic [11:0] b);
    return {b[SNES_RIGHT], b[SNES_LEFT], b[SNES_DOWN], b[SNES_UP],
            b[SNES_START], b[SNES_SELECT], b[SNES_B], b[SNES_A]};
  endfunction

endpackage

// File: rtl/nes_joypad_shifter.sv
// One NES controller shift register with a saturating read counter.
module nes_joypad_shifter
  import nes_joypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] buttons,
  output logic       serial
);

  localparam logic [3:0] CNT_FULL = 4'd8;

  logic [7:0] shreg;
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= CNT_FULL;
    end else if (load) begin
      shreg <= buttons;
      cnt   <= '0;
    end else if (shift && (cnt != CNT_FULL)) begin
      shreg <= {1'b0, shreg[7:1]};
      cnt   <= cnt + 4'd1;
    end
  end

  // Once all eight bits are gone the real pad reports 1s forever.
  assign serial = (cnt == CNT_FULL) ? 1'b1 : shreg[0];

endmodule

// File: rtl/nes_joypad_port.sv
// NES controller register block at $4016/$4017 fed by SNES button vectors.
// Optional turbo on X/Y: define NES_JOY_TURBO_EN.
module nes_joypad_port
  import nes_joypad_pkg::*;
#(
  parameter logic [7:0]  OPEN_BUS  = OPEN_BUS_DEFAULT,
  parameter int unsigned TURBO_DIV = 833333
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [11:0] BUTTONS1,
  input  logic [11:0] BUTTONS2,
  input  logic [15:0] CPU_ADDR,
  input  logic [7:0]  CPU_WDATA,
  input  logic        CPU_WR,
  input  logic        CPU_RD,
  output logic [7:0]  CPU_RDATA,
  output logic        CPU_RVALID,
  output logic        HIT,
  output logic        STROBE
);

  localparam logic [31:0] TURBO_DIV_VEC = 32'(TURBO_DIV);

  logic       sel_joy1, sel_joy2;
  logic       rd_hit;
  logic       shift1, shift2;
  logic       serial1, serial2;
  logic       rd_bit;
  logic [11:0] eff1, eff2;
  logic [7:0] nes1, nes2;
  logic       unused_ok;

  assign sel_joy1 = (CPU_ADDR == ADDR_JOY1);
  assign sel_joy2 = (CPU_ADDR == ADDR_JOY2);
  assign HIT      = sel_joy1 | sel_joy2;
  assign rd_hit   = CPU_RD & HIT;

`ifdef NES_JOY_TURBO_EN
  logic [31:0] turbo_cnt;
  logic        turbo_phase;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      turbo_cnt   <= '0;
      turbo_phase <= 1'b0;
    end else if (turbo_cnt == TURBO_DIV_VEC - 32'd1) begin
      turbo_cnt   <= '0;
      turbo_phase <= ~turbo_phase;
    end else begin
      turbo_cnt   <= turbo_cnt + 32'd1;
    end
  end

  always_comb begin
    eff1 = BUTTONS1;
    eff2 = BUTTONS2;
    eff1[SNES_A] = BUTTONS1[SNES_A] | (BUTTONS1[SNES_X] & turbo_phase);
    eff1[SNES_B] = BUTTONS1[SNES_B] | (BUTTONS1[SNES_Y] & turbo_phase);
    eff2[SNES_A] = BUTTONS2[SNES_A] | (BUTTONS2[SNES_X] & turbo_phase);
    eff2[SNES_B] = BUTTONS2[SNES_B] | (BUTTONS2[SNES_Y] & turbo_phase);
  end
`else
  assign eff1 = BUTTONS1;
  assign eff2 = BUTTONS2;
`endif

  assign nes1 = snes_to_nes(eff1);
  assign nes2 = snes_to_nes(eff2);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      STROBE <= 1'b0;
    end else if (CPU_WR && sel_joy1) begin
      STROBE <= CPU_WDATA[0];
    end
  end

  // Load keys off the pre-write strobe so a 1->0 write still captures this cycle;
  // a read coincident with any write returns the old bit without advancing.
  assign shift1 = rd_hit & sel_joy1 & ~STROBE & ~CPU_WR;
  assign shift2 = rd_hit & sel_joy2 & ~STROBE & ~CPU_WR;

  nes_joypad_shifter u_port1 (
    .clk     (CLOCK),
    .rst     (RESET),
    .load    (STROBE),
    .shift   (shift1),
    .buttons (nes1),
    .serial  (serial1)
  );

  nes_joypad_shifter u_port2 (
    .clk     (CLOCK),
    .rst     (RESET),
    .load    (STROBE),
    .shift   (shift2),
    .buttons (nes2),
    .serial  (serial2)
  );

  assign rd_bit = sel_joy2 ? serial2 : serial1;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      CPU_RDATA  <= '0;
      CPU_RVALID <= 1'b0;
    end else begin
      CPU_RVALID <= rd_hit;
      if (rd_hit) begin
        CPU_RDATA <= {OPEN_BUS[7:1], rd_bit};
      end
    end
  end

  assign unused_ok = ^{BUTTONS1[11:9], BUTTONS1[1], BUTTONS2[11:9], BUTTONS2[1],
                       CPU_WDATA[7:1], OPEN_BUS[0], TURBO_DIV_VEC};

endmodule
